radix_4_ntt_ctrl: RTL and testbench

Sequencer that runs a full in-place radix-4 DIF NTT over a coefficient memory by driving one radix-4 butterfly processing element. It produces per-butterfly read addresses, the twiddle index and the delayed write-back addresses, one butterfly per cycle. Between stages it drains the read-to-write pipeline so the next stage never reads stale data. It sits between the host start/done handshake and the coefficient RAM / twiddle ROM / PE datapath.

---
 rtl/radix_4_ntt_ctrl.sv | 175 +++++++++++++++++
 tb/tb_radix_4_ntt_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix_4_ntt_ctrl.sv
// Radix-4 DIF NTT sequencer: issues one butterfly per cycle and delays its addresses LAT cycles for write-back.
// Defining RADIX4_NTT_CTRL_STALL_EN adds a stall input that freezes the whole sequencer while it is high.
module radix_4_ntt_ctrl #(
    parameter int unsigned LOGP = 8,
    parameter int unsigned LAT  = 2
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
`ifdef RADIX4_NTT_CTRL_STALL_EN
    input  logic                                          stall,
`endif
    output logic                                          busy,
    output logic                                          done,
    output logic [((LOGP / 2 > 1) ? $clog2(LOGP / 2) : 1)-1:0] stage,
    output logic                                          rd_en,
    output logic [LOGP-1:0]                               rd_addr_a,
    output logic [LOGP-1:0]                               rd_addr_b,
    output logic [LOGP-1:0]                               rd_addr_c,
    output logic [LOGP-1:0]                               rd_addr_d,
    output logic [LOGP-3:0]                               tf_addr,
    output logic                                          wr_en,
    output logic [LOGP-1:0]                               wr_addr_a,
    output logic [LOGP-1:0]                               wr_addr_b,
    output logic [LOGP-1:0]                               wr_addr_c,
    output logic [LOGP-1:0]                               wr_addr_d
);
    localparam int unsigned POINTS = 32'd1 << LOGP;
    localparam int unsigned STAGES = LOGP / 2;
    localparam int unsigned SW     = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int unsigned CW     = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [LOGP-3:0] KLAST = '1;
    localparam logic [SW-1:0]   SLAST = SW'(STAGES - 1);
    localparam logic [CW-1:0]   CLAST = CW'(LAT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

    state_e                 st_q, st_d;
    logic [LOGP-3:0]        k_q, k_d;
    logic [SW-1:0]          s_q, s_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rd_en_q, rd_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [3:0][LOGP-1:0]   ra_q, ra_d;
    logic [LOGP-3:0]        tf_q, tf_d;
    logic [LAT-1:0]         dv_q, dv_d;
    logic [3:0][LOGP-1:0]   da_q [LAT];
    logic [3:0][LOGP-1:0]   da_d [LAT];
    logic [LOGP-1:0]        q, kx, j, base;
    logic                   adv;

`ifdef RADIX4_NTT_CTRL_STALL_EN
    assign adv = ~stall;
`else
    assign adv = 1'b1;
`endif

    always_comb begin
        st_d    = st_q;
        k_d     = k_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        rd_en_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (start) begin
                    st_d    = StIssue;
                    k_d     = '0;
                    s_d     = '0;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StIssue: begin
                if (k_q == KLAST) begin
                    st_d  = StDrain;
                    cnt_d = '0;
                end else begin
                    k_d     = k_q + 1'b1;
                    rd_en_d = 1'b1;
                end
            end
            StDrain: begin
                if (cnt_q == CLAST) begin
                    if (s_q == SLAST) begin
                        st_d   = StFinish;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        st_d    = StIssue;
                        s_d     = s_q + 1'b1;
                        k_d     = '0;
                        rd_en_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFinish: st_d = StIdle;
            default:  st_d = StIdle;
        endcase
    end

    // Q is a power of two, so k/Q and k%Q reduce to masking with Q-1.
    always_comb begin
        q    = LOGP'(POINTS >> 2) >> {s_d, 1'b0};
        kx   = {2'b00, k_d};
        j    = kx & (q - LOGP'(1));
        base = ((kx & ~(q - LOGP'(1))) << 2) | j;
        ra_d = ra_q;
        tf_d = tf_q;
        if (rd_en_d) begin
            ra_d[0] = base;
            ra_d[1] = base + q;
            ra_d[2] = base + (q << 1);
            ra_d[3] = base + (q << 1) + q;
            tf_d    = j[LOGP-3:0] << {s_d, 1'b0};
        end
    end

    always_comb begin
        dv_d[0] = rd_en_q;
        da_d[0] = ra_q;
        for (int i = 1; i < LAT; i++) begin
            dv_d[i] = dv_q[i-1];
            da_d[i] = da_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= StIdle;
            k_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ra_q    <= '0;
            tf_q    <= '0;
            dv_q    <= '0;
            for (int i = 0; i < LAT; i++) da_q[i] <= '0;
        end else if (adv) begin
            st_q    <= st_d;
            k_q     <= k_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ra_q    <= ra_d;
            tf_q    <= tf_d;
            dv_q    <= dv_d;
            for (int i = 0; i < LAT; i++) da_q[i] <= da_d[i];
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign stage     = s_q;
    assign rd_en     = rd_en_q & adv;
    assign rd_addr_a = ra_q[0];
    assign rd_addr_b = ra_q[1];
    assign rd_addr_c = ra_q[2];
    assign rd_addr_d = ra_q[3];
    assign tf_addr   = tf_q;
    assign wr_en     = dv_q[LAT-1] & adv;
    assign wr_addr_a = da_q[LAT-1][0];
    assign wr_addr_b = da_q[LAT-1][1];
    assign wr_addr_c = da_q[LAT-1][2];
    assign wr_addr_d = da_q[LAT-1][3];
endmodule

// File: tb/tb_radix_4_ntt_ctrl.sv
// Scoreboard bench for radix_4_ntt_ctrl: two instances (LAT=2, LAT=5) checked against a loop-based NTT schedule model.
module tb_radix_4_ntt_ctrl;
    localparam int P  = 256;
    localparam int ST = 4;

    typedef struct {
        int cyc;
        int a0, a1, a2, a3;
        int tf;
        int st;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
`ifdef RADIX4_NTT_CTRL_STALL_EN
    logic stall = 1'b0;
`endif
    always #5 clk = ~clk;

    logic       busy [2];
    logic       done [2];
    logic       rd_en [2];
    logic       wr_en [2];
    logic [1:0] stage [2];
    logic [7:0] ra [2][4];
    logic [7:0] wa [2][4];
    logic [5:0] tf [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        radix_4_ntt_ctrl #(.LOGP(8), .LAT(g == 0 ? 2 : 5)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
`ifdef RADIX4_NTT_CTRL_STALL_EN
            .stall     (stall),
`endif
            .busy      (busy[g]),
            .done      (done[g]),
            .stage     (stage[g]),
            .rd_en     (rd_en[g]),
            .rd_addr_a (ra[g][0]),
            .rd_addr_b (ra[g][1]),
            .rd_addr_c (ra[g][2]),
            .rd_addr_d (ra[g][3]),
            .tf_addr   (tf[g]),
            .wr_en     (wr_en[g]),
            .wr_addr_a (wa[g][0]),
            .wr_addr_b (wa[g][1]),
            .wr_addr_c (wa[g][2]),
            .wr_addr_d (wa[g][3])
        );
    end

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    ev_t  rdq [2][$];
    ev_t  wrq [2][$];
    int   dnq [2][$];
    int   bz_lo [2];
    int   bz_hi [2];
    int   idle_from [2];
    int   stall_base = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 5;
    endfunction

    // Events at or after the first stalled cycle slip by the ten stalled cycles.
    function automatic int sh(input int c);
        return (stall_base >= 0 && c >= stall_base) ? c + 10 : c;
    endfunction

    task automatic chk(input string nm, input int d, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", nm, d, cyc, got, want);
        end
    endtask

    task automatic unexpected(input string nm, input int d);
        tests++;
        fails++;
        $display("FAIL %s dut%0d cyc=%0d got=1 want=0 (no event expected)", nm, d, cyc);
    endtask

    task automatic accept(input int d, input int t0);
        int L;
        ev_t e;
        L = P / 4 + lat_of(d);
        for (int s = 0; s < ST; s++) begin
            int q;
            q = P >> (2 * s + 2);
            for (int g = 0; g < P / (4 * q); g++) begin
                for (int j = 0; j < q; j++) begin
                    int base, c;
                    base = 4 * g * q + j;
                    c    = t0 + s * L + g * q + j;
                    e.a0 = base;
                    e.a1 = base + q;
                    e.a2 = base + 2 * q;
                    e.a3 = base + 3 * q;
                    e.tf = j * (4 ** s);
                    e.st = s;
                    e.cyc = sh(c);
                    rdq[d].push_back(e);
                    e.cyc = sh(c + lat_of(d));
                    wrq[d].push_back(e);
                end
            end
        end
        dnq[d].push_back(sh(t0 + ST * L));
        bz_lo[d]     = t0;
        bz_hi[d]     = sh(t0 + ST * L - 1);
        idle_from[d] = sh(t0 + ST * L) + 2;
    endtask

    task automatic mon(input int d);
        ev_t e;
        chk("busy", d, int'(busy[d]), (cyc >= bz_lo[d] && cyc <= bz_hi[d]) ? 1 : 0);
        if (rd_en[d]) begin
            if (rdq[d].size() == 0) unexpected("rd_en", d);
            else begin
                e = rdq[d].pop_front();
                chk("rd_cycle", d, cyc, e.cyc);
                chk("rd_addr_a", d, int'(ra[d][0]), e.a0);
                chk("rd_addr_b", d, int'(ra[d][1]), e.a1);
                chk("rd_addr_c", d, int'(ra[d][2]), e.a2);
                chk("rd_addr_d", d, int'(ra[d][3]), e.a3);
                chk("tf_addr", d, int'(tf[d]), e.tf);
                chk("stage", d, int'(stage[d]), e.st);
            end
        end
        if (wr_en[d]) begin
            if (wrq[d].size() == 0) unexpected("wr_en", d);
            else begin
                e = wrq[d].pop_front();
                chk("wr_cycle", d, cyc, e.cyc);
                chk("wr_addr_a", d, int'(wa[d][0]), e.a0);
                chk("wr_addr_b", d, int'(wa[d][1]), e.a1);
                chk("wr_addr_c", d, int'(wa[d][2]), e.a2);
                chk("wr_addr_d", d, int'(wa[d][3]), e.a3);
            end
        end
        if (done[d]) begin
            if (dnq[d].size() == 0) unexpected("done", d);
            else chk("done_cycle", d, cyc, dnq[d].pop_front());
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    // Drives one cycle's inputs at posedge+2 and predicts which DUTs accept the start.
    task automatic step(input bit st);
        start = st;
`ifdef RADIX4_NTT_CTRL_STALL_EN
        stall = (stall_base >= 0 && cyc >= stall_base && cyc < stall_base + 10);
`endif
        if (st && rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (cyc + 1 >= idle_from[d]) accept(d, cyc + 1);
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic check_quiet(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_busy"}, d, int'(busy[d]), 0);
            chk({tag, "_done"}, d, int'(done[d]), 0);
            chk({tag, "_rd_en"}, d, int'(rd_en[d]), 0);
            chk({tag, "_wr_en"}, d, int'(wr_en[d]), 0);
            chk({tag, "_stage"}, d, int'(stage[d]), 0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_quiet("midrst");
        for (int d = 0; d < 2; d++) begin
            rdq[d].delete();
            wrq[d].delete();
            dnq[d].delete();
            bz_lo[d]     = 0;
            bz_hi[d]     = -1;
            idle_from[d] = 1 << 30;
        end
        repeat (3) step(1'b0);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) idle_from[d] = cyc + 1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rdq[0].size() + rdq[1].size() + wrq[0].size() + wrq[1].size()
                + dnq[0].size() + dnq[1].size()) != 0 && n < 2000) begin
            step(1'b0);
            n++;
        end
        repeat (3) step(1'b0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            bz_lo[d]     = 0;
            bz_hi[d]     = -1;
            idle_from[d] = 1 << 30;
        end
        #1 rst_n = 1'b0;
        #1;
        check_quiet("reset");
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                chk("reset_rd_addr", d, int'(ra[d][i]), 0);
                chk("reset_wr_addr", d, int'(wa[d][i]), 0);
            end
            chk("reset_tf_addr", d, int'(tf[d]), 0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) idle_from[d] = cyc + 1;

        // Single transform with random start pulses while busy.
        step(1'b1);
        repeat (300) step($urandom_range(0, 3) == 0);
        wait_idle();

        // Start held high: restarts only from IDLE, never from the done cycle.
        repeat (700) step(1'b1);
        wait_idle();

        // Reset 100 cycles into a transform, then a fresh run.
        step(1'b1);
        repeat (99) step(1'b0);
        do_reset();
        step(1'b1);
        wait_idle();

`ifdef RADIX4_NTT_CTRL_STALL_EN
        stall_base = cyc + 1 + 39;
        step(1'b1);
        repeat (320) step(1'b0);
        wait_idle();
        stall_base = -1;
`endif

        repeat (1500) step($urandom_range(0, 15) == 0);
        wait_idle();

        for (int d = 0; d < 2; d++) begin
            chk("rd_left", d, rdq[d].size(), 0);
            chk("wr_left", d, wrq[d].size(), 0);
            chk("done_left", d, dnq[d].size(), 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
